// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit uP control path: opcodes, ALU codes,
// sequencer states and the bus-source selector used by the opcode classifier.
package cpu_pkg;

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANDI = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;
    localparam logic [2:0] ALU_NAND   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH1 = 2'd1,
        S_FETCH2 = 2'd2,
        S_EXEC   = 2'd3
    } state_t;

    // Which single source drives the 4-bit data bus during EXEC.
    typedef enum logic [2:0] {
        BUS_NONE    = 3'd0,
        BUS_OPERAND = 3'd1,
        BUS_IN      = 3'd2,
        BUS_ACC     = 3'd3,
        BUS_RAM     = 3'd4
    } bus_src_t;

endpackage

// File: rtl/cpu_control_sequencer_opcode_classify.sv
// Combinational opcode decoder: instruction length, branch class, ALU
// function, accumulator/flag writes and the bus source for EXEC.
import cpu_pkg::*;

module opcode_classify (
    input  logic [3:0] opcode,
    output logic       two_byte,
    output logic       is_branch,
    output logic [2:0] alu_control,
    output logic       acc_load,
    output logic       flags_load,
    output bus_src_t   bus_src,
    output logic       ram_write,
    output logic       out_load
);

    // Decode one opcode into its control attributes.
    always_comb begin
        two_byte    = 1'b0;
        is_branch   = 1'b0;
        alu_control = ALU_PASS_A;
        acc_load    = 1'b0;
        flags_load  = 1'b0;
        bus_src     = BUS_NONE;
        ram_write   = 1'b0;
        out_load    = 1'b0;
        case (opcode)
            OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
                two_byte  = 1'b1;
                is_branch = 1'b1;
            end
            OP_CMPI: begin
                bus_src     = BUS_OPERAND;
                alu_control = ALU_SUB;
                flags_load  = 1'b1;
            end
            OP_CMPM: begin
                two_byte    = 1'b1;
                bus_src     = BUS_RAM;
                alu_control = ALU_SUB;
                flags_load  = 1'b1;
            end
            OP_LIT: begin
                bus_src     = BUS_OPERAND;
                alu_control = ALU_PASS_B;
                acc_load    = 1'b1;
            end
            OP_IN: begin
                bus_src     = BUS_IN;
                alu_control = ALU_PASS_B;
                acc_load    = 1'b1;
            end
            OP_LD: begin
                two_byte    = 1'b1;
                bus_src     = BUS_RAM;
                alu_control = ALU_PASS_B;
                acc_load    = 1'b1;
            end
            OP_ST: begin
                two_byte  = 1'b1;
                bus_src   = BUS_ACC;
                ram_write = 1'b1;
            end
            OP_ADDI: begin
                bus_src     = BUS_OPERAND;
                alu_control = ALU_ADD;
                acc_load    = 1'b1;
                flags_load  = 1'b1;
            end
            OP_ADDM: begin
                two_byte    = 1'b1;
                bus_src     = BUS_RAM;
                alu_control = ALU_ADD;
                acc_load    = 1'b1;
                flags_load  = 1'b1;
            end
            OP_OUT: begin
                bus_src  = BUS_ACC;
                out_load = 1'b1;
            end
            OP_NANDI: begin
                bus_src     = BUS_OPERAND;
                alu_control = ALU_NAND;
                acc_load    = 1'b1;
                flags_load  = 1'b1;
            end
            OP_NANDM: begin
                two_byte    = 1'b1;
                bus_src     = BUS_RAM;
                alu_control = ALU_NAND;
                acc_load    = 1'b1;
                flags_load  = 1'b1;
            end
            default: begin
                two_byte = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control sequencer for the 4-bit uP: IDLE/FETCH1/FETCH2/EXEC FSM,
// low address byte capture, C/Z flags and run/step control.
import cpu_pkg::*;

module cpu_control_sequencer #(
    parameter int unsigned ADDR_W        = 12,
    parameter bit          START_RUNNING = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [3:0]        instr,
    input  logic [3:0]        operand,
    input  logic [7:0]        program_byte,
    input  logic              alu_c,
    input  logic              alu_z,
    output logic              pc_enable,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_value,
    output logic              fetch_enable,
    output logic [2:0]        alu_control,
    output logic              acc_load,
    output logic              oe_operand,
    output logic              oe_in,
    output logic              oe_acc,
    output logic              out_load,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic              flag_c,
    output logic              flag_z,
    output logic              busy,
    output logic              instr_done
);

    state_t     state_q, state_d;
    logic [7:0] addr_lo_q, addr_lo_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_z_q, flag_z_d;
    logic       start_pending_q, start_pending_d;

    logic [3:0] cls_opcode;
    logic       cls_two_byte;
    logic       cls_is_branch;
    logic [2:0] cls_alu_control;
    logic       cls_acc_load;
    logic       cls_flags_load;
    bus_src_t   cls_bus_src;
    logic       cls_ram_write;
    logic       cls_out_load;
    logic       branch_taken;

    // The fetch register is not yet loaded in FETCH1, so the length decision
    // there comes from the ROM byte; every later state decodes the latched opcode.
    assign cls_opcode = (state_q == S_FETCH1) ? program_byte[7:4] : instr;

    opcode_classify u_classify (
        .opcode      (cls_opcode),
        .two_byte    (cls_two_byte),
        .is_branch   (cls_is_branch),
        .alu_control (cls_alu_control),
        .acc_load    (cls_acc_load),
        .flags_load  (cls_flags_load),
        .bus_src     (cls_bus_src),
        .ram_write   (cls_ram_write),
        .out_load    (cls_out_load)
    );

    assign pc_load_value = {operand, addr_lo_q};
    assign ram_address   = {operand, addr_lo_q};
    assign flag_c        = flag_c_q;
    assign flag_z        = flag_z_q;
    assign busy          = (state_q != S_IDLE);

    // Branch condition evaluated against the flags held before this instruction.
    always_comb begin
        branch_taken = 1'b0;
        case (instr)
            OP_JC:   branch_taken = flag_c_q;
            OP_JNC:  branch_taken = !flag_c_q;
            OP_JZ:   branch_taken = flag_z_q;
            OP_JNZ:  branch_taken = !flag_z_q;
            OP_JMP:  branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state, address byte, flag update and per-state control outputs.
    always_comb begin
        state_d         = state_q;
        addr_lo_d       = addr_lo_q;
        flag_c_d        = flag_c_q;
        flag_z_d        = flag_z_q;
        start_pending_d = 1'b0;
        pc_enable       = 1'b0;
        pc_load         = 1'b0;
        fetch_enable    = 1'b0;
        alu_control     = ALU_PASS_A;
        acc_load        = 1'b0;
        oe_operand      = 1'b0;
        oe_in           = 1'b0;
        oe_acc          = 1'b0;
        out_load        = 1'b0;
        ram_cs          = 1'b0;
        ram_we          = 1'b0;
        instr_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || step || (START_RUNNING && start_pending_q)) begin
                    state_d = S_FETCH1;
                end
            end
            S_FETCH1: begin
                fetch_enable = 1'b1;
                pc_enable    = 1'b1;
                state_d      = cls_two_byte ? S_FETCH2 : S_EXEC;
            end
            S_FETCH2: begin
                addr_lo_d = program_byte;
                pc_enable = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                instr_done  = 1'b1;
                alu_control = cls_alu_control;
                acc_load    = cls_acc_load;
                oe_operand  = (cls_bus_src == BUS_OPERAND);
                oe_in       = (cls_bus_src == BUS_IN);
                oe_acc      = (cls_bus_src == BUS_ACC);
                ram_cs      = (cls_bus_src == BUS_RAM) || cls_ram_write;
                ram_we      = cls_ram_write;
                out_load    = cls_out_load;
                pc_load     = cls_is_branch && branch_taken;
                if (cls_flags_load) begin
                    flag_c_d = alu_c;
                    flag_z_d = alu_z;
                end
                state_d = run ? S_FETCH1 : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, address byte and flag registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_lo_q       <= '0;
            flag_c_q        <= 1'b0;
            flag_z_q        <= 1'b0;
            start_pending_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            addr_lo_q       <= addr_lo_d;
            flag_c_q        <= flag_c_d;
            flag_z_q        <= flag_z_d;
            start_pending_q <= start_pending_d;
        end
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: a table of single-step instructions
// with hand-computed EXEC controls, plus run/step/reset corner sequences.
module tb_cpu_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  instr;
    logic [3:0]  operand;
    logic [7:0]  program_byte;
    logic        alu_c = 1'b0;
    logic        alu_z = 1'b0;
    logic        pc_enable, pc_load, fetch_enable, acc_load;
    logic        oe_operand, oe_in, oe_acc, out_load, ram_cs, ram_we;
    logic        flag_c, flag_z, busy, instr_done;
    logic [11:0] pc_load_value, ram_address;
    logic [2:0]  alu_control;

    logic [7:0]  rom [4096];
    logic [11:0] pc;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        c;
        logic        z;
        logic [10:0] ctl;      // {pc_load, alu[2:0], acc_load, oe_operand, oe_in, oe_acc, out_load, ram_cs, ram_we}
        logic        chk_addr;
        logic [11:0] addr;
        logic [1:0]  flags;    // {flag_c, flag_z} after the instruction
        int          cycles;
    } vec_t;

    vec_t vecs [21];

    cpu_control_sequencer #(.ADDR_W(12), .START_RUNNING(1'b0)) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .step          (step),
        .instr         (instr),
        .operand       (operand),
        .program_byte  (program_byte),
        .alu_c         (alu_c),
        .alu_z         (alu_z),
        .pc_enable     (pc_enable),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .fetch_enable  (fetch_enable),
        .alu_control   (alu_control),
        .acc_load      (acc_load),
        .oe_operand    (oe_operand),
        .oe_in         (oe_in),
        .oe_acc        (oe_acc),
        .out_load      (out_load),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_address   (ram_address),
        .flag_c        (flag_c),
        .flag_z        (flag_z),
        .busy          (busy),
        .instr_done    (instr_done)
    );

    always #5 clock = ~clock;

    // Environment: program counter, ROM and fetch register around the sequencer.
    assign program_byte = rom[pc];
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            instr   <= '0;
            operand <= '0;
        end else begin
            if (pc_load) pc <= pc_load_value;
            else if (pc_enable) pc <= pc + 12'd1;
            if (fetch_enable) {instr, operand} <= program_byte;
        end
    end

    logic [10:0] ctl_now;
    logic [40:0] outs_all;
    assign ctl_now  = {pc_load, alu_control, acc_load, oe_operand, oe_in, oe_acc, out_load, ram_cs, ram_we};
    assign outs_all = {pc_enable, pc_load, pc_load_value, fetch_enable, ctl_now[9:0], ram_address,
                       flag_c, flag_z, busy, instr_done};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1);
        logic [11:0] nxt;
        nxt = pc + 12'd1;
        rom[pc]  = b0;
        rom[nxt] = b1;
    endtask

    // Single-step one instruction from IDLE and compare its EXEC cycle.
    task automatic run_one(input vec_t v, input string tag);
        int cyc;
        load_rom(v.b0, v.b1);
        alu_c = v.c;
        alu_z = v.z;
        step  = 1'b1;
        @(negedge clock);
        step = 1'b0;
        cyc  = 1;
        check({tag, "_fetch1"}, {fetch_enable, pc_enable, pc_load}, 3'b110);
        while (instr_done !== 1'b1 && cyc < 6) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_done"}, instr_done, 1'b1);
        check({tag, "_ctl"}, ctl_now, v.ctl);
        check({tag, "_cycles"}, cyc, v.cycles);
        if (v.chk_addr) check({tag, "_addr"}, {pc_load_value, ram_address}, {v.addr, v.addr});
        @(negedge clock);
        check({tag, "_idle"}, {busy, instr_done}, 2'b00);
        check({tag, "_flags"}, {flag_c, flag_z}, v.flags);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;

        vecs[0]  = '{8'h47, 8'h00, 1'b1, 1'b1, 11'b0_010_1_1_0_0_0_0_0, 1'b0, 12'h000, 2'b00, 2}; // LIT 7
        vecs[1]  = '{8'h23, 8'h00, 1'b1, 1'b1, 11'b0_001_0_1_0_0_0_0_0, 1'b0, 12'h000, 2'b11, 2}; // CMPI
        vecs[2]  = '{8'h85, 8'h00, 1'b0, 1'b0, 11'b1_000_0_0_0_0_0_0_0, 1'b1, 12'h500, 2'b11, 3}; // JZ taken
        vecs[3]  = '{8'h01, 8'hAB, 1'b0, 1'b0, 11'b1_000_0_0_0_0_0_0_0, 1'b1, 12'h1AB, 2'b11, 3}; // JC taken
        vecs[4]  = '{8'h12, 8'h34, 1'b0, 1'b0, 11'b0_000_0_0_0_0_0_0_0, 1'b1, 12'h234, 2'b11, 3}; // JNC not
        vecs[5]  = '{8'h93, 8'hCD, 1'b0, 1'b0, 11'b0_000_0_0_0_0_0_0_0, 1'b1, 12'h3CD, 2'b11, 3}; // JNZ not
        vecs[6]  = '{8'hA5, 8'h00, 1'b0, 1'b0, 11'b0_011_1_1_0_0_0_0_0, 1'b0, 12'h000, 2'b00, 2}; // ADDI
        vecs[7]  = '{8'h85, 8'h00, 1'b1, 1'b1, 11'b0_000_0_0_0_0_0_0_0, 1'b1, 12'h500, 2'b00, 3}; // JZ not
        vecs[8]  = '{8'h16, 8'h78, 1'b0, 1'b0, 11'b1_000_0_0_0_0_0_0_0, 1'b1, 12'h678, 2'b00, 3}; // JNC taken
        vecs[9]  = '{8'h99, 8'hEF, 1'b0, 1'b0, 11'b1_000_0_0_0_0_0_0_0, 1'b1, 12'h9EF, 2'b00, 3}; // JNZ taken
        vecs[10] = '{8'hC1, 8'h23, 1'b0, 1'b0, 11'b1_000_0_0_0_0_0_0_0, 1'b1, 12'h123, 2'b00, 3}; // JMP
        vecs[11] = '{8'h72, 8'h10, 1'b0, 1'b0, 11'b0_000_0_0_0_1_0_1_1, 1'b1, 12'h210, 2'b00, 3}; // ST
        vecs[12] = '{8'h64, 8'hFF, 1'b1, 1'b1, 11'b0_010_1_0_0_0_0_1_0, 1'b1, 12'h4FF, 2'b00, 3}; // LD
        vecs[13] = '{8'h50, 8'h00, 1'b1, 1'b1, 11'b0_010_1_0_1_0_0_0_0, 1'b0, 12'h000, 2'b00, 2}; // IN
        vecs[14] = '{8'hD0, 8'h00, 1'b1, 1'b1, 11'b0_000_0_0_0_1_1_0_0, 1'b0, 12'h000, 2'b00, 2}; // OUT
        vecs[15] = '{8'h3A, 8'hBC, 1'b1, 1'b0, 11'b0_001_0_0_0_0_0_1_0, 1'b1, 12'hABC, 2'b10, 3}; // CMPM
        vecs[16] = '{8'hB1, 8'h02, 1'b0, 1'b1, 11'b0_011_1_0_0_0_0_1_0, 1'b1, 12'h102, 2'b01, 3}; // ADDM
        vecs[17] = '{8'h8F, 8'h0F, 1'b0, 1'b0, 11'b1_000_0_0_0_0_0_0_0, 1'b1, 12'hF0F, 2'b01, 3}; // JZ taken
        vecs[18] = '{8'hE3, 8'h00, 1'b1, 1'b1, 11'b0_100_1_1_0_0_0_0_0, 1'b0, 12'h000, 2'b11, 2}; // NANDI
        vecs[19] = '{8'hF7, 8'h77, 1'b0, 1'b0, 11'b0_100_1_0_0_0_0_1_0, 1'b1, 12'h777, 2'b00, 3}; // NANDM
        vecs[20] = '{8'h05, 8'h55, 1'b0, 1'b0, 11'b0_000_0_0_0_0_0_0_0, 1'b1, 12'h555, 2'b00, 3}; // JC not

        // Power-on reset.
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_outputs", outs_all, '0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_stays_idle", {busy, fetch_enable}, 2'b00);

        for (int i = 0; i < 21; i++) run_one(vecs[i], $sformatf("v%0d", i));

        // run held for a 1-byte instruction, dropped during EXEC.
        load_rom(8'h47, 8'h47);
        run = 1'b1;
        @(negedge clock);
        check("run_fetch1", {busy, fetch_enable, pc_enable}, 3'b111);
        @(negedge clock);
        check("run_exec", {instr_done, ctl_now}, {1'b1, 11'b0_010_1_1_0_0_0_0_0});
        run = 1'b0;
        @(negedge clock);
        check("run_back_idle", {busy, instr_done}, 2'b00);

        // run dropped in FETCH1 of a 2-byte instruction completes it.
        load_rom(8'hC4, 8'h56);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        check("drop_fetch2", {busy, pc_enable, instr_done, fetch_enable}, 4'b1100);
        @(negedge clock);
        check("drop_exec", {instr_done, pc_load, pc_enable, pc_load_value}, {3'b110, 12'h456});
        @(negedge clock);
        check("drop_idle", busy, 1'b0);

        // Step pulse during EXEC is ignored.
        load_rom(8'h47, 8'h00);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        check("step2_exec", instr_done, 1'b1);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        check("step2_ignored", busy, 1'b0);
        @(negedge clock);
        check("step2_still_idle", {busy, instr_done}, 2'b00);

        // Reset asserted in EXEC of a JMP after a CMPI set both flags.
        run_one('{8'h29, 8'h00, 1'b1, 1'b1, 11'b0_001_0_1_0_0_0_0_0, 1'b0, 12'h000, 2'b11, 2}, "pre_rst");
        load_rom(8'hC7, 8'h89);
        run = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_pre_exec", {instr_done, pc_load, pc_load_value}, {2'b11, 12'h789});
        reset = 1'b1;
        #1;
        check("rst_mid_exec_outputs", outs_all, '0);
        run = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_after_release", {busy, flag_c, flag_z, ram_address}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
